// File: rtl/instr_byte_feeder.sv
// instr_byte_feeder
//   Upstream stage of the instruction shift register. Bytes from the external
//   valid/ready port are buffered in a small FIFO. Exactly two bytes per
//   instruction are handed to the shift register. The assembled instruction is
//   then checked, held until the core reports instr_done, and cleared.
//
//   Optional feature macro: FEEDER_STATS_EN
//     defined   : instruction / error statistics counters are built.
//     undefined : no counter flops; o_instr_count and o_err_count read 0.
module instr_byte_feeder #(
  parameter int FIFO_DEPTH     = 4,    // power of 2, >= 2
  parameter int TIMEOUT_CYCLES = 255   // >= 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_in_byte,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  output logic                        o_data_ready,
  output logic [7:0]                  o_serial_in,
  output logic                        o_sr_clear,
  input  logic                        i_sr_valid,
  input  logic                        i_sr_error,
  input  logic                        i_instr_done,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_instr_err,
  output logic                        o_timeout_err,
  output logic [15:0]                 o_instr_count,
  output logic [7:0]                  o_err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_SEND_HI   = 3'd1,
    S_SEND_LO   = 3'd2,
    S_CHECK     = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_to_cnt;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_sending;
  logic            w_timeout;
  logic            w_check_fail;

  // FIFO status, handshakes, timeout detect and the CHECK verdict.
  always_comb begin
    w_empty   = (r_count == {CW{1'b0}});
    w_full    = (r_count == CW'(FIFO_DEPTH));
    // The counter only reaches the limit after that many empty SEND_LO cycles.
    w_timeout = (r_state == S_SEND_LO) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
    // A timed-out instruction is abandoned, so no byte is handed over that cycle.
    w_sending = ((r_state == S_SEND_HI) || (r_state == S_SEND_LO)) && !w_timeout;
    w_pop     = !rst && w_sending && !w_empty;
    w_push    = !rst && i_in_valid && !w_full;
    // sr_valid wins if both flags are raised; sr_error or no flag at all is a failure.
    w_check_fail = !rst && (r_state == S_CHECK) && !i_sr_valid &&
                   (i_sr_error || !i_sr_valid);
  end

  assign o_in_ready    = !w_full;
  assign o_data_ready  = w_pop;
  assign o_serial_in   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_sr_clear    = (r_state == S_CLEAR);
  assign o_busy        = (r_state != S_WAIT_DONE);
  assign o_fifo_count  = r_count;
  assign o_instr_err   = w_check_fail;
  assign o_timeout_err = !rst && w_timeout;

  // FIFO storage: write the incoming byte at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_byte;
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Instruction sequencing FSM with the SEND_LO starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CLEAR;
      r_to_cnt <= {TW{1'b0}};
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_state  <= S_SEND_HI;
          r_to_cnt <= {TW{1'b0}};
        end
        S_SEND_HI: begin
          r_to_cnt <= {TW{1'b0}};
          if (w_pop) begin
            r_state <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (w_timeout) begin
            r_state  <= S_CLEAR;
            r_to_cnt <= {TW{1'b0}};
          end else if (w_pop) begin
            r_state  <= S_CHECK;
            r_to_cnt <= {TW{1'b0}};
          end else begin
            // No pop and no timeout means the FIFO was empty this cycle.
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          r_to_cnt <= {TW{1'b0}};
          if (i_sr_valid) begin
            r_state <= S_WAIT_DONE;
          end else begin
            r_state <= S_CLEAR;
          end
        end
        S_WAIT_DONE: begin
          r_to_cnt <= {TW{1'b0}};
          if (i_instr_done) begin
            r_state <= S_CLEAR;
          end
        end
        default: begin
          r_state  <= S_CLEAR;
          r_to_cnt <= {TW{1'b0}};
        end
      endcase
    end
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] r_instr_count;
  logic [7:0]  r_err_count;

  // Accepted-instruction counter (wrapping) and error counter (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= 16'd0;
      r_err_count   <= 8'd0;
    end else begin
      if ((r_state == S_CHECK) && i_sr_valid) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
      if ((w_check_fail || w_timeout) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_instr_count = r_instr_count;
  assign o_err_count   = r_err_count;
`else
  assign o_instr_count = 16'd0;
  assign o_err_count   = 8'd0;
`endif

endmodule

// File: tb/tb_instr_byte_feeder.sv
// Bench for instr_byte_feeder: a behavioural shift register answers CHECK,
// a byte scoreboard follows every data_ready, directed checks cover timing.
module tb_instr_byte_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        instr_done = 1'b0;
  logic        in_ready;
  logic        data_ready;
  logic [7:0]  serial_in;
  logic        sr_clear;
  logic        sr_valid;
  logic        sr_error;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        instr_err;
  logic        timeout_err;
  logic [15:0] instr_count;
  logic [7:0]  err_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  int          m_good = 0;
  int          m_bad = 0;
  logic [1:0]  sr_cnt = 2'd0;
  logic [7:0]  sr_lo = 8'h00;
  logic        force_none = 1'b0;
  int          k;

  always #5 clk = ~clk;

  instr_byte_feeder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_byte    (in_byte),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_data_ready (data_ready),
    .o_serial_in  (serial_in),
    .o_sr_clear   (sr_clear),
    .i_sr_valid   (sr_valid),
    .i_sr_error   (sr_error),
    .i_instr_done (instr_done),
    .o_busy       (busy),
    .o_fifo_count (fifo_count),
    .o_instr_err  (instr_err),
    .o_timeout_err(timeout_err),
    .o_instr_count(instr_count),
    .o_err_count  (err_count)
  );

  // Opcode legality of the low byte: [2:0] values 6 and 7 are illegal.
  function automatic logic op_legal(input logic [7:0] b);
    return (b[2:0] < 3'd6);
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural shift register: collects two bytes, flags opcode legality.
  always @(posedge clk) begin
    if (rst || sr_clear) begin
      sr_cnt <= 2'd0;
    end else if (data_ready && (sr_cnt < 2'd2)) begin
      sr_cnt <= sr_cnt + 2'd1;
      sr_lo  <= serial_in;
    end
  end
  assign sr_valid = !force_none && (sr_cnt == 2'd2) && op_legal(sr_lo);
  assign sr_error = !force_none && (sr_cnt == 2'd2) && !op_legal(sr_lo);

  // Scoreboard: every byte handed over must be the next byte accepted.
  always @(negedge clk) begin
    if (!rst && data_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pop", 16'(data_ready), 16'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("serial_in", 16'(serial_in), 16'(mon_exp));
      end
    end
  end

  // Entered just after a negedge in CLEAR, or in SEND_HI with an empty FIFO.
  task automatic load_pair(input logic [7:0] hi, input logic [7:0] lo);
    logic good;
    good = op_legal(lo) && !force_none;
    #1; in_valid = 1'b1; in_byte = hi; exp_q.push_back(hi);
    @(negedge clk);
    check_eq("lp_dr_hi", 16'(data_ready), 16'd1);
    check_eq("lp_cnt_hi", 16'(fifo_count), 16'd1);
    #1; in_byte = lo; exp_q.push_back(lo);
    @(negedge clk);
    check_eq("lp_dr_lo", 16'(data_ready), 16'd1);
    check_eq("lp_cnt_pushpop", 16'(fifo_count), 16'd1);
    #1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("lp_chk_dr", 16'(data_ready), 16'd0);
    check_eq("lp_instr_err", 16'(instr_err), 16'(!good));
    check_eq("lp_chk_busy", 16'(busy), 16'd1);
    @(negedge clk);
    check_eq("lp_busy", 16'(busy), 16'(!good));
    check_eq("lp_sr_clear", 16'(sr_clear), 16'(!good));
    check_eq("lp_err_1cyc", 16'(instr_err), 16'd0);
    if (good) m_good++; else m_bad++;
  endtask

  // From WAIT_DONE: one-cycle instr_done, CLEAR for one cycle, then SEND_HI.
  task automatic pulse_done();
    #1; instr_done = 1'b1;
    @(negedge clk);
    check_eq("done_sr_clear", 16'(sr_clear), 16'd1);
    #1; instr_done = 1'b0;
    @(negedge clk);
    check_eq("done_sr_clear_1cyc", 16'(sr_clear), 16'd0);
  endtask

  // Two buffered legal bytes go out back to back right after pulse_done.
  task automatic drain_pair();
    check_eq("dp_dr_hi", 16'(data_ready), 16'd1);
    @(negedge clk);
    check_eq("dp_dr_lo", 16'(data_ready), 16'd1);
    @(negedge clk);
    check_eq("dp_chk_dr", 16'(data_ready), 16'd0);
    @(negedge clk);
    check_eq("dp_busy", 16'(busy), 16'd0);
    m_good++;
  endtask

  task automatic check_stats(input string tag);
`ifdef FEEDER_STATS_EN
    check_eq({tag, "_instr_count"}, instr_count, 16'(m_good));
    check_eq({tag, "_err_count"}, 16'(err_count), 16'(m_bad));
`else
    check_eq({tag, "_instr_count"}, instr_count, 16'd0);
    check_eq({tag, "_err_count"}, 16'(err_count), 16'd0);
`endif
  endtask

  initial begin
    // Reset: two clock edges with rst high.
    @(negedge clk);
    check_eq("rst_data_ready", 16'(data_ready), 16'd0);
    check_eq("rst_instr_err", 16'(instr_err), 16'd0);
    check_eq("rst_timeout_err", 16'(timeout_err), 16'd0);
    check_eq("rst_fifo_count", 16'(fifo_count), 16'd0);
    check_eq("rst_in_ready", 16'(in_ready), 16'd1);
    check_eq("rst_instr_count", instr_count, 16'd0);
    check_eq("rst_err_count", 16'(err_count), 16'd0);
    @(negedge clk);
    check_eq("rst_sr_clear", 16'(sr_clear), 16'd1);
    #1; rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_sr_clear_1cyc", 16'(sr_clear), 16'd0);
    check_eq("post_rst_busy", 16'(busy), 16'd1);
    check_eq("empty_serial_in", 16'(serial_in), 16'd0);

    // 1: good instruction, held until instr_done.
    load_pair(8'h12, 8'h01);
    for (int i = 0; i < 3; i++) begin
      #1; in_valid = 1'b1; in_byte = 8'hE0 + 8'(i); exp_q.push_back(8'hE0 + 8'(i));
      @(negedge clk);
      check_eq("t1_wait_no_pop", 16'(data_ready), 16'd0);
      check_eq("t1_wait_busy", 16'(busy), 16'd0);
    end
    #1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_wait_fill", 16'(fifo_count), 16'd3);
    pulse_done();
    drain_pair();   // E0,E1 ([2:0]=1 legal)
    pulse_done();
    // E2 alone: send it with a legal partner.
    check_eq("t1_dr_e2", 16'(data_ready), 16'd1);
    #1; in_valid = 1'b1; in_byte = 8'h03; exp_q.push_back(8'h03);
    @(negedge clk);
    check_eq("t1_dr_lo2", 16'(data_ready), 16'd1);
    #1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t1_busy2", 16'(busy), 16'd0);
    m_good++;
    pulse_done();

    // 2: illegal opcode, then next pair without instr_done; then no flag at all.
    load_pair(8'h34, 8'h07);
    load_pair(8'h56, 8'h02);
    pulse_done();
    force_none = 1'b1;
    load_pair(8'h78, 8'h03);
    force_none = 1'b0;

    // 3: hold WAIT_DONE and offer five bytes into a depth-4 FIFO.
    load_pair(8'h9A, 8'h04);
    for (int i = 0; i < 5; i++) begin
      #1; in_valid = 1'b1; in_byte = 8'hA0 + 8'(i);
      if (i < 4) exp_q.push_back(8'hA0 + 8'(i));
      @(negedge clk);
      check_eq("t3_fifo_count", 16'(fifo_count), (i < 4) ? 16'(i + 1) : 16'd4);
      check_eq("t3_in_ready", 16'(in_ready), (i < 3) ? 16'd1 : 16'd0);
      check_eq("t3_no_pop", 16'(data_ready), 16'd0);
    end
    #1; in_valid = 1'b0;
    pulse_done();
    drain_pair();
    pulse_done();
    drain_pair();
    pulse_done();
    check_eq("t3_drained", 16'(fifo_count), 16'd0);

    // 4: single byte then starvation in SEND_LO.
    #1; in_valid = 1'b1; in_byte = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    check_eq("t4_dr_hi", 16'(data_ready), 16'd1);
    #1; in_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!timeout_err && (k < 400)) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_timeout_latency", 16'(k), 16'd255);
    @(negedge clk);
    check_eq("t4_sr_clear", 16'(sr_clear), 16'd1);
    check_eq("t4_timeout_1cyc", 16'(timeout_err), 16'd0);
    check_eq("t4_fifo_count", 16'(fifo_count), 16'd0);
    check_eq("t4_serial_zero", 16'(serial_in), 16'd0);
    m_bad++;
    check_stats("t4");

    // 5: reset in SEND_LO with two bytes still buffered.
    load_pair(8'hBC, 8'h05);
    for (int i = 0; i < 3; i++) begin
      #1; in_valid = 1'b1; in_byte = 8'hC0 + 8'(i); exp_q.push_back(8'hC0 + 8'(i));
      @(negedge clk);
    end
    #1; in_valid = 1'b0;
    pulse_done();
    check_eq("t5_hi_count", 16'(fifo_count), 16'd3);
    @(negedge clk);
    check_eq("t5_lo_count", 16'(fifo_count), 16'd2);
    check_eq("t5_lo_dr", 16'(data_ready), 16'd1);
    #1; rst = 1'b1; exp_q.delete(); m_good = 0; m_bad = 0;
    @(negedge clk);
    check_eq("t5_fifo_count", 16'(fifo_count), 16'd0);
    check_eq("t5_data_ready", 16'(data_ready), 16'd0);
    check_eq("t5_sr_clear", 16'(sr_clear), 16'd1);
    check_stats("t5");
    #1; rst = 1'b0;
    @(negedge clk);
    check_eq("t5_sr_clear_1cyc", 16'(sr_clear), 16'd0);

    // 6: three good and one bad instruction after reset.
    load_pair(8'hD0, 8'h01);
    pulse_done();
    load_pair(8'hD2, 8'h02);
    pulse_done();
    load_pair(8'hD4, 8'h03);
    pulse_done();
    load_pair(8'hD6, 8'h06);
    check_eq("t6_good", 16'(m_good), 16'd3);
    check_stats("t6");

    repeat (3) @(negedge clk);
    check_eq("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
